led_status_ctrl: RTL and testbench

- Parametrised LED status driver for the stopwatch/timer designs; it replaces fixed-width, fixed-rate blink logic.
- Takes the timer mode and countdown status and drives an LED_W-wide bank with per-mode patterns: blink, bar graph, alarm flash and chaser.
- Adds a bounded alarm with acknowledge, and global PWM brightness.
- Sits between the timer control FSM and the board LED pins.

---
 rtl/led_status_pkg.sv | 24 ++
 rtl/led_status_if.sv | 26 ++
 rtl/led_status_ctrl_pwm_gate.sv | 33 +++
 rtl/led_status_ctrl.sv | 140 ++++++++++++++
 tb/tb_led_status_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_status_pkg.sv
// Shared encodings and helpers for the LED status driver: mode codes,
// controller state codes and the millisecond-to-cycle conversion.
package led_status_pkg;

  localparam logic [1:0] MODE_RUN       = 2'd0;
  localparam logic [1:0] MODE_PAUSE     = 2'd1;
  localparam logic [1:0] MODE_COUNTDOWN = 2'd2;
  localparam logic [1:0] MODE_CHASE     = 2'd3;

  typedef logic [2:0] state_t;
  localparam state_t S_BLINK  = 3'd0;
  localparam state_t S_BAR    = 3'd1;
  localparam state_t S_ALARM  = 3'd2;
  localparam state_t S_SILENT = 3'd3;
  localparam state_t S_CHASE  = 3'd4;

  // A period that rounds to zero cycles would never tick, so clamp it to one.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    int unsigned cyc;
    cyc = (clk_hz / 1000) * ms;
    return (cyc == 0) ? 1 : cyc;
  endfunction

endpackage

// File: rtl/led_status_if.sv
// Bundle between the timer control FSM (master) and the LED status driver (slave).
interface led_status_if #(
  parameter int unsigned LED_W    = 8,
  parameter int unsigned PWM_BITS = 4
);
  localparam int unsigned BAR_W = $clog2(LED_W + 1);

  logic [1:0]          mode;
  logic                cd_done;
  logic [BAR_W-1:0]    cd_bar;
  logic                alarm_ack;
  logic [PWM_BITS-1:0] brightness;
  logic [LED_W-1:0]    led;
  logic                alarm_active;

  modport master (
    output mode, cd_done, cd_bar, alarm_ack, brightness,
    input  led, alarm_active
  );

  modport slave (
    input  mode, cd_done, cd_bar, alarm_ack, brightness,
    output led, alarm_active
  );

endinterface

// File: rtl/led_status_ctrl_pwm_gate.sv
// Global brightness PWM: free-running counter, duty compare and the
// registered LED output stage.
module led_pwm_gate #(
  parameter int unsigned LED_W    = 8,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LED_W-1:0]    i_pattern,
  input  logic [PWM_BITS-1:0] i_brightness,
  output logic [LED_W-1:0]    o_led
);

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [LED_W-1:0]    r_led;
  logic                w_en;

  // All-ones means fully on; a plain compare would leave one dark slot per period.
  assign w_en = (&i_brightness) || (r_pwm_cnt < i_brightness);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pwm_cnt <= '0;
      r_led     <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_led     <= i_pattern & {LED_W{w_en}};
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_status_ctrl.sv
// LED status driver: maps timer mode and countdown status to blink, bar graph,
// bounded alarm flash and chaser patterns, then applies global PWM brightness.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int unsigned LED_W         = 8,
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned RUN_MS        = 1000,
  parameter int unsigned PAUSE_MS      = 333,
  parameter int unsigned ALARM_MS      = 100,
  parameter int unsigned CHASE_MS      = 125,
  parameter int unsigned ALARM_TOGGLES = 50,
  parameter int unsigned PWM_BITS      = 4,
  parameter logic [7:0]  IDLE_PATTERN  = 8'h55
) (
  input  logic         clk,
  input  logic         rst,
  led_status_if.slave  io_status
);

  localparam int unsigned CYC_RUN   = ms_to_cycles(CLK_HZ, RUN_MS);
  localparam int unsigned CYC_PAUSE = ms_to_cycles(CLK_HZ, PAUSE_MS);
  localparam int unsigned CYC_ALARM = ms_to_cycles(CLK_HZ, ALARM_MS);
  localparam int unsigned CYC_CHASE = ms_to_cycles(CLK_HZ, CHASE_MS);
  localparam int unsigned CYC_M01   = (CYC_RUN > CYC_PAUSE) ? CYC_RUN : CYC_PAUSE;
  localparam int unsigned CYC_M23   = (CYC_ALARM > CYC_CHASE) ? CYC_ALARM : CYC_CHASE;
  localparam int unsigned CYC_MAX   = (CYC_M01 > CYC_M23) ? CYC_M01 : CYC_M23;
  localparam int unsigned TMR_W     = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int unsigned BAR_W     = $clog2(LED_W + 1);
  localparam logic [LED_W-1:0] IDLE_FULL = LED_W'({4{IDLE_PATTERN}});

  state_t           r_state, w_state_next;
  logic [1:0]       r_mode;
  logic [LED_W-1:0] r_pattern, w_pattern_next, w_bar;
  logic [TMR_W-1:0] r_timer, w_timer_next, w_cyc_m1;
  logic [7:0]       r_count, w_count_next;
  logic             r_alarm_active;
  logic             w_entry, w_timed, w_tick;

  // Bar graph: LED gi lit when cd_bar exceeds gi, which also clamps cd_bar > LED_W.
  for (genvar gi = 0; gi < LED_W; gi++) begin : g_bar
    assign w_bar[gi] = (BAR_W'(gi) < io_status.cd_bar);
  end

  always_comb begin
    w_state_next = r_state;
    case (io_status.mode)
      MODE_RUN, MODE_PAUSE: w_state_next = S_BLINK;
      MODE_CHASE:           w_state_next = S_CHASE;
      default: begin
        if (!io_status.cd_done)
          w_state_next = S_BAR;
        else if (r_state == S_ALARM)
          w_state_next = (io_status.alarm_ack || r_count == 8'(ALARM_TOGGLES)) ? S_SILENT : S_ALARM;
        else if (r_state == S_SILENT)
          w_state_next = S_SILENT;
        else
          w_state_next = S_ALARM;
      end
    endcase
  end

  always_comb begin
    w_timed  = 1'b1;
    w_cyc_m1 = TMR_W'(CYC_RUN - 1);
    case (r_state)
      S_BLINK: w_cyc_m1 = (r_mode == MODE_PAUSE) ? TMR_W'(CYC_PAUSE - 1) : TMR_W'(CYC_RUN - 1);
      S_ALARM: w_cyc_m1 = TMR_W'(CYC_ALARM - 1);
      S_CHASE: w_cyc_m1 = TMR_W'(CYC_CHASE - 1);
      default: w_timed  = 1'b0;
    endcase
  end

  assign w_tick  = w_timed && (r_timer == w_cyc_m1);
  // A RUN/PAUSE swap stays in S_BLINK but still counts as a fresh entry.
  assign w_entry = (w_state_next != r_state) || (io_status.mode != r_mode);

  always_comb begin
    w_pattern_next = r_pattern;
    w_timer_next   = '0;
    w_count_next   = r_count;
    if (w_entry) begin
      case (w_state_next)
        S_BLINK:  w_pattern_next = IDLE_FULL;
        S_BAR:    w_pattern_next = w_bar;
        S_ALARM:  begin
          w_pattern_next = '1;
          w_count_next   = '0;
        end
        S_SILENT: w_pattern_next = '0;
        default:  w_pattern_next = LED_W'(1);
      endcase
    end else begin
      if (w_timed && !w_tick)
        w_timer_next = r_timer + 1'b1;
      case (r_state)
        S_BLINK: if (w_tick) w_pattern_next = ~r_pattern;
        S_BAR:   w_pattern_next = w_bar;
        S_ALARM: if (w_tick) begin
          w_pattern_next = ~r_pattern;
          w_count_next   = r_count + 8'd1;
        end
        S_CHASE: if (w_tick) w_pattern_next = {r_pattern[LED_W-2:0], r_pattern[LED_W-1]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_BLINK;
      r_mode         <= MODE_RUN;
      r_pattern      <= IDLE_FULL;
      r_timer        <= '0;
      r_count        <= '0;
      r_alarm_active <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_mode         <= io_status.mode;
      r_pattern      <= w_pattern_next;
      r_timer        <= w_timer_next;
      r_count        <= w_count_next;
      r_alarm_active <= (w_state_next == S_ALARM);
    end
  end

  assign io_status.alarm_active = r_alarm_active;

  led_pwm_gate #(
    .LED_W    (LED_W),
    .PWM_BITS (PWM_BITS)
  ) u_pwm_gate (
    .clk          (clk),
    .rst          (rst),
    .i_pattern    (r_pattern),
    .i_brightness (io_status.brightness),
    .o_led        (io_status.led)
  );

endmodule

// File: tb/tb_led_status_ctrl.sv
// Self-checking bench for led_status_ctrl: scenario tasks with randomized
// stimulus compared against an elapsed-time reference model.
module tb_led_status_ctrl;

  localparam int C_BLINK  = 0;
  localparam int C_BAR    = 1;
  localparam int C_ALARM  = 2;
  localparam int C_SILENT = 3;
  localparam int C_CHASE  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_status_if #(.LED_W(8), .PWM_BITS(4)) bus ();

  led_status_ctrl #(
    .LED_W(8), .CLK_HZ(1000), .RUN_MS(10), .PAUSE_MS(4), .ALARM_MS(2),
    .CHASE_MS(3), .ALARM_TOGGLES(4), .PWM_BITS(4), .IDLE_PATTERN(8'h55)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .io_status (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pattern derived from cycles elapsed since entering a behaviour.
  int         m_cls, m_since, m_cyc;
  logic [1:0] m_mode_prev;
  logic [7:0] m_pat, m_led;
  logic       m_alarm;

  function automatic logic [7:0] bar_of(input int n);
    int k;
    k = (n > 8) ? 8 : n;
    return 8'((1 << k) - 1);
  endfunction

  task automatic model_reset();
    m_cls = C_BLINK; m_since = 0; m_cyc = 0; m_mode_prev = 2'd0;
    m_pat = 8'h55; m_led = 8'h00; m_alarm = 1'b0;
  endtask

  task automatic model_edge();
    int  cls_new, per, p;
    bit  entry;
    p     = m_cyc % 16;
    m_led = (bus.brightness == 4'hF || p < int'(bus.brightness)) ? m_pat : 8'h00;
    m_cyc++;
    case (bus.mode)
      2'd0, 2'd1: cls_new = C_BLINK;
      2'd3:       cls_new = C_CHASE;
      default: begin
        if (!bus.cd_done)          cls_new = C_BAR;
        else if (m_cls == C_ALARM) cls_new = (bus.alarm_ack || (m_since / 2) >= 4) ? C_SILENT : C_ALARM;
        else if (m_cls == C_SILENT) cls_new = C_SILENT;
        else                        cls_new = C_ALARM;
      end
    endcase
    entry   = (cls_new != m_cls) || (bus.mode != m_mode_prev);
    m_since = entry ? 0 : m_since + 1;
    per     = (bus.mode == 2'd1) ? 4 : 10;
    case (cls_new)
      C_BLINK:  m_pat = ((m_since / per) % 2) ? 8'hAA : 8'h55;
      C_BAR:    m_pat = bar_of(int'(bus.cd_bar));
      C_ALARM:  m_pat = ((m_since / 2) % 2) ? 8'h00 : 8'hFF;
      C_SILENT: m_pat = 8'h00;
      default:  m_pat = 8'(1 << ((m_since / 3) % 8));
    endcase
    m_cls       = cls_new;
    m_mode_prev = bus.mode;
    m_alarm     = (cls_new == C_ALARM);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    bus.mode = 2'd0; bus.cd_done = 1'b0; bus.cd_bar = '0;
    bus.alarm_ack = 1'b0; bus.brightness = 4'hF;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.mode = 2'd0; bus.cd_done = 1'b0; bus.cd_bar = '0;
    bus.alarm_ack = 1'b0; bus.brightness = 4'hF;
    @(negedge clk);
    n_checks++;
    if ({bus.led, bus.alarm_active} !== 9'h000)
      $display("FAIL reset_hold led=%h alarm=%b exp led=00 alarm=0", bus.led, bus.alarm_active);
    else n_pass++;
    model_reset();
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.led !== 8'h55 || bus.alarm_active !== 1'b0)
      $display("FAIL reset_first_clk led=%h alarm=%b exp led=55 alarm=0", bus.led, bus.alarm_active);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_blink();
    logic [7:0] exp;
    apply_reset();
    for (int e = 1; e <= 21; e++) begin
      tick();
      n_checks++;
      if ({bus.led, bus.alarm_active} !== {m_led, m_alarm})
        $display("FAIL blink_model e=%0d led=%h alarm=%b exp %h %b", e, bus.led, bus.alarm_active, m_led, m_alarm);
      else n_pass++;
      if (e == 1 || e == 10 || e == 11 || e == 20 || e == 21) begin
        exp = (((e - 1) / 10) % 2) ? 8'hAA : 8'h55;
        n_checks++;
        if (bus.led !== exp) $display("FAIL blink_edge e=%0d led=%h exp %h", e, bus.led, exp);
        else n_pass++;
      end
    end
    $display("test_blink done");
  endtask

  task automatic test_mode_switch();
    int s;
    apply_reset();
    s = $urandom_range(3, 9);
    for (int e = 1; e < s; e++) tick();
    bus.mode = 2'd1;
    for (int k = 0; k <= 9; k++) begin
      tick();
      n_checks++;
      if ({bus.led, bus.alarm_active} !== {m_led, m_alarm})
        $display("FAIL switch_model k=%0d led=%h exp %h", k, bus.led, m_led);
      else n_pass++;
      if (k == 4 || k == 5) begin
        n_checks++;
        if (bus.led !== ((k == 5) ? 8'hAA : 8'h55))
          $display("FAIL switch_edge s=%0d k=%0d led=%h exp %h", s, k, bus.led, (k == 5) ? 8'hAA : 8'h55);
        else n_pass++;
      end
    end
    $display("test_mode_switch done (switch at edge %0d)", s);
  endtask

  task automatic test_countdown();
    logic [7:0] exp;
    apply_reset();
    bus.mode = 2'd2; bus.cd_bar = 4'd3;
    repeat (3) tick();
    n_checks++;
    if (bus.led !== 8'h07) $display("FAIL bar3 led=%h exp 07", bus.led); else n_pass++;
    bus.cd_bar = 4'd9;
    repeat (2) tick();
    n_checks++;
    if (bus.led !== 8'hFF) $display("FAIL bar9 led=%h exp FF", bus.led); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      bus.cd_bar = 4'($urandom_range(0, 15));
      repeat (2) tick();
      n_checks++;
      if (bus.led !== m_led || bus.led !== bar_of(int'(bus.cd_bar)))
        $display("FAIL bar_rand cd_bar=%0d led=%h exp %h", bus.cd_bar, bus.led, m_led);
      else n_pass++;
    end
    bus.cd_done = 1'b1;
    tick();
    n_checks++;
    if (bus.alarm_active !== 1'b1) $display("FAIL alarm_start alarm=%b exp 1", bus.alarm_active);
    else n_pass++;
    for (int k = 1; k <= 11; k++) begin
      tick();
      n_checks++;
      if ({bus.led, bus.alarm_active} !== {m_led, m_alarm})
        $display("FAIL alarm_model k=%0d led=%h alarm=%b exp %h %b", k, bus.led, bus.alarm_active, m_led, m_alarm);
      else n_pass++;
      if (k <= 10) begin
        exp = (k == 10) ? 8'h00 : ((((k - 1) / 2) % 2) ? 8'h00 : 8'hFF);
        n_checks++;
        if (bus.led !== exp || bus.alarm_active !== (k <= 8))
          $display("FAIL alarm_seq k=%0d led=%h alarm=%b exp %h %b", k, bus.led, bus.alarm_active, exp, k <= 8);
        else n_pass++;
      end
    end
    $display("test_countdown done");
  endtask

  task automatic test_ack();
    int off;
    apply_reset();
    bus.mode = 2'd2; bus.cd_bar = 4'($urandom_range(0, 8));
    repeat (3) tick();
    bus.cd_done = 1'b1;
    tick();
    off = $urandom_range(1, 7);
    for (int k = 1; k < off; k++) tick();
    bus.alarm_ack = 1'b1;
    tick();
    bus.alarm_ack = 1'b0;
    n_checks++;
    if (bus.alarm_active !== 1'b0) $display("FAIL ack_alarm off=%0d alarm=%b exp 0", off, bus.alarm_active);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.led !== 8'h00) $display("FAIL ack_led off=%0d led=%h exp 00", off, bus.led); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) bus.alarm_ack = 1'b1;
      tick();
      bus.alarm_ack = 1'b0;
      n_checks++;
      if ({bus.led, bus.alarm_active} !== 9'h000 || m_led !== 8'h00)
        $display("FAIL silent_hold k=%0d led=%h alarm=%b exp 00 0", k, bus.led, bus.alarm_active);
      else n_pass++;
    end
    bus.cd_done = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (bus.led !== bar_of(int'(bus.cd_bar)) || bus.led !== m_led)
      $display("FAIL bar_return led=%h exp %h", bus.led, bar_of(int'(bus.cd_bar)));
    else n_pass++;
    $display("test_ack done (ack %0d cycles after entry)", off);
  endtask

  task automatic test_chase();
    logic [7:0] exp;
    int on_cnt;
    apply_reset();
    bus.mode = 2'd3;
    for (int k = 1; k <= 27; k++) begin
      tick();
      n_checks++;
      if ({bus.led, bus.alarm_active} !== {m_led, m_alarm})
        $display("FAIL chase_model k=%0d led=%h exp %h", k, bus.led, m_led);
      else n_pass++;
      if (k >= 2) begin
        exp = 8'(1 << (((k - 2) / 3) % 8));
        n_checks++;
        if (bus.led !== exp) $display("FAIL chase_step k=%0d led=%h exp %h", k, bus.led, exp);
        else n_pass++;
      end
    end
    bus.brightness = 4'd0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if (bus.led !== 8'h00 || m_led !== 8'h00) $display("FAIL dark k=%0d led=%h exp 00", k, bus.led);
      else n_pass++;
    end
    bus.brightness = 4'd8;
    on_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (bus.led !== 8'h00) on_cnt++;
      n_checks++;
      if (bus.led !== m_led) $display("FAIL pwm_model k=%0d led=%h exp %h", k, bus.led, m_led);
      else n_pass++;
    end
    n_checks++;
    if (on_cnt !== 16) $display("FAIL pwm_duty on=%0d exp 16", on_cnt); else n_pass++;
    $display("test_chase done");
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.mode = 2'd2; bus.cd_done = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (bus.alarm_active !== 1'b1 || m_alarm !== 1'b1)
      $display("FAIL pre_reset_alarm alarm=%b exp 1", bus.alarm_active);
    else n_pass++;
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.led, bus.alarm_active} !== 9'h000)
      $display("FAIL async_clear led=%h alarm=%b exp 00 0", bus.led, bus.alarm_active);
    else n_pass++;
    bus.cd_done = 1'b0;
    bus.cd_bar  = 4'd5;
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if ({bus.led, bus.alarm_active} !== {m_led, m_alarm} || bus.alarm_active !== 1'b0)
        $display("FAIL post_reset k=%0d led=%h alarm=%b exp %h 0", k, bus.led, bus.alarm_active, m_led);
      else n_pass++;
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    int len, errs;
    errs = 0;
    apply_reset();
    for (int seg = 0; seg < 300; seg++) begin
      bus.mode       = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      bus.cd_done    = 1'($urandom_range(0, 1));
      bus.cd_bar     = 4'($urandom_range(0, 15));
      bus.brightness = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        bus.alarm_ack = ($urandom_range(0, 9) == 0);
        tick();
        n_checks++;
        if ({bus.led, bus.alarm_active} !== {m_led, m_alarm}) begin
          errs++;
          $display("FAIL random seg=%0d mode=%0d cd=%b led=%h alarm=%b exp %h %b",
                   seg, bus.mode, bus.cd_done, bus.led, bus.alarm_active, m_led, m_alarm);
        end else n_pass++;
      end
    end
    bus.alarm_ack = 1'b0;
    $display("test_random done (%0d mismatching cycles)", errs);
  endtask

  initial begin
    test_reset();
    test_blink();
    test_mode_switch();
    test_countdown();
    test_ack();
    test_chase();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
